pixel_writer: RTL and testbench
===============================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 Parameter COORD_WIDTH, default 32, width of signed x/y coordinates from the rasterizer.
REQ-002 Parameter H_RES, default 320, framebuffer width in pixels.
REQ-003 Parameter V_RES, default 180, framebuffer height in pixels.
REQ-004 Parameter COLOR_WIDTH, default 8, pixel data width.
REQ-005 Parameter ADDR_WIDTH, default $clog2(H_RES*V_RES), framebuffer address width.
REQ-006 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-007 rst_in  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  single-cycle pulse that begins a frame.
REQ-009 clear_en  input  1  sampled with start; 1 = clear framebuffer before accepting pixels.
REQ-010 clear_color  input  COLOR_WIDTH  fill value for the clear phase, sampled with start.
REQ-011 x, y  input  COORD_WIDTH each  signed pixel coordinate from the rasterizer.
REQ-012 color  input  COLOR_WIDTH  pixel colour, qualified by drawing.
REQ-013 drawing  input  1  x/y/color valid this cycle; no backpressure.
REQ-014 raster_done  input  1  rasterizer completion pulse.
REQ-015 fb_addr  output  ADDR_WIDTH  framebuffer write address.
REQ-016 fb_data  output  COLOR_WIDTH  framebuffer write data.
REQ-017 fb_we  output  1  framebuffer write enable.
REQ-018 ready  output  1  high only in ACCEPT; rasterizer may be started.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 frame_done  output  1  single-cycle completion pulse.
REQ-021 pixels_written  output  32  count of in-bounds pixels written this frame.
REQ-022 pixels_clipped  output  32  count of out-of-bounds pixels discarded this frame.

Function
REQ-023 FSM states SHALL be IDLE, CLEAR, ACCEPT, FLUSH.
REQ-024 IDLE + start: clear_en=1 -> CLEAR, clear_en=0 -> ACCEPT; both counters zeroed same edge.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 CLEAR: one write per cycle, fb_we=1, fb_addr 0 to H_RES*V_RES-1 ascending, fb_data = latched clear_color; after last address -> ACCEPT; exactly H_RES*V_RES writes.
REQ-027 ACCEPT, drawing=1, 0<=x<H_RES and 0<=y<V_RES (signed compare): next cycle fb_we=1, fb_addr=y*H_RES+x, fb_data=color; pixels_written+1.
REQ-028 ACCEPT, drawing=1, out of bounds (incl. negative): no write; pixels_clipped+1.
REQ-029 Pixel path latency SHALL be exactly 1 cycle, one pixel per cycle sustained, no drops in ACCEPT.
REQ-030 drawing in IDLE, CLEAR, FLUSH SHALL be ignored: no write, no count.
REQ-031 ACCEPT + raster_done -> FLUSH; a pixel with drawing=1 on the same cycle SHALL still be processed.
REQ-032 FLUSH lasts 1 cycle (final write drains); frame_done=1 during FLUSH; then -> IDLE.
REQ-033 fb_we SHALL be 0 in IDLE and whenever no write is issued; fb_addr/fb_data hold last value.
REQ-034 Counters saturate at 2^32-1; hold value after frame_done until next start.
REQ-035 Address multiply SHALL use ADDR_WIDTH result bits; in-bound inputs never overflow.

Reset
REQ-036 rst_in=1 SHALL immediately force IDLE, fb_we=0, fb_addr=0, fb_data=0, ready=0, busy=0, frame_done=0, both counters=0, independent of clk_in.
REQ-037 Reset mid-CLEAR or mid-ACCEPT SHALL abort with no further writes; first start after release begins a fresh frame.

Verification (H_RES=8, V_RES=4)
REQ-038 start, clear_en=1, clear_color=0x3C -> 32 consecutive fb_we cycles, addr 0..31, data 0x3C, then ready=1.
REQ-039 ACCEPT, drawing with (x,y)=(3,2), color=0xA5 -> next cycle fb_we=1, fb_addr=19, fb_data=0xA5, pixels_written=1.
REQ-040 ACCEPT, pixels (-1,0), (8,1), (0,4), (7,3) back-to-back -> single write at addr 31, pixels_clipped=3, pixels_written=1.
REQ-041 drawing (1,1) coincident with raster_done -> write addr 9 during FLUSH, frame_done one cycle, then IDLE, busy=0.
REQ-042 rst_in pulsed at clear address 10 -> fb_we=0 immediately, busy=0; start with clear_en=0 -> ready=1 next cycle, counters 0.
REQ-043 start while busy and drawing in IDLE -> no state change, no writes, counters unchanged.

Source files
------------

// File: rtl/pixel_writer.sv
// Pixel writer: takes signed pixel coordinates from a rasterizer and turns them
// into framebuffer writes. It can optionally clear the framebuffer first, it
// drops out-of-bounds pixels, and it counts written and clipped pixels per frame.
module pixel_writer #(
    parameter int COORD_WIDTH = 32,
    parameter int H_RES       = 320,
    parameter int V_RES       = 180,
    parameter int COLOR_WIDTH = 8,
    parameter int ADDR_WIDTH  = $clog2(H_RES * V_RES)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start,
    input  logic                   clear_en,
    input  logic [COLOR_WIDTH-1:0] clear_color,
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    input  logic [COLOR_WIDTH-1:0] color,
    input  logic                   drawing,
    input  logic                   raster_done,
    output logic [ADDR_WIDTH-1:0]  fb_addr,
    output logic [COLOR_WIDTH-1:0] fb_data,
    output logic                   fb_we,
    output logic                   ready,
    output logic                   busy,
    output logic                   frame_done,
    output logic [31:0]            pixels_written,
    output logic [31:0]            pixels_clipped
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ACCEPT,
        FLUSH
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]         LAST_ADDR = ADDR_WIDTH'(H_RES * V_RES - 1);
    localparam logic [ADDR_WIDTH-1:0]         H_RES_A   = ADDR_WIDTH'(H_RES);
    localparam logic signed [COORD_WIDTH-1:0] X_LIM     = COORD_WIDTH'(H_RES);
    localparam logic signed [COORD_WIDTH-1:0] Y_LIM     = COORD_WIDTH'(V_RES);

    state_t                  state;
    logic                    in_bounds;
    logic [ADDR_WIDTH-1:0]   pixel_addr;

    // Signed bounds check: a set sign bit means the coordinate is negative
    // and therefore off-screen.
    always_comb begin
        in_bounds = !x[COORD_WIDTH-1] && ($signed(x) < X_LIM) &&
                    !y[COORD_WIDTH-1] && ($signed(y) < Y_LIM);
    end

    // Row-major address. In-bounds coordinates always fit in ADDR_WIDTH, so
    // truncating the inputs and the product does no harm.
    always_comb begin
        pixel_addr = y[ADDR_WIDTH-1:0] * H_RES_A + x[ADDR_WIDTH-1:0];
    end

    // Status flags are decoded directly from the state register.
    assign ready      = (state == ACCEPT);
    assign busy       = (state != IDLE);
    assign frame_done = (state == FLUSH);

    // Frame sequencer. The framebuffer write port and the counters are registered here.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            fb_we          <= 1'b0;
            fb_addr        <= '0;
            fb_data        <= '0;
            pixels_written <= '0;
            pixels_clipped <= '0;
        end else begin
            // No write unless a branch below issues one; addr/data hold.
            fb_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pixels_written <= '0;
                        pixels_clipped <= '0;
                        if (clear_en) begin
                            // First clear write leaves on this same edge.
                            state   <= CLEAR;
                            fb_we   <= 1'b1;
                            fb_addr <= '0;
                            fb_data <= clear_color;
                        end else begin
                            state <= ACCEPT;
                        end
                    end
                end
                CLEAR: begin
                    // fb_data still holds the clear colour latched at start.
                    if (fb_addr == LAST_ADDR) begin
                        state <= ACCEPT;
                    end else begin
                        fb_we   <= 1'b1;
                        fb_addr <= fb_addr + ADDR_WIDTH'(1);
                    end
                end
                ACCEPT: begin
                    if (drawing) begin
                        if (in_bounds) begin
                            fb_we   <= 1'b1;
                            fb_addr <= pixel_addr;
                            fb_data <= color;
                            if (pixels_written != '1) begin
                                pixels_written <= pixels_written + 32'd1;
                            end
                        end else if (pixels_clipped != '1) begin
                            pixels_clipped <= pixels_clipped + 32'd1;
                        end
                    end
                    // A pixel that arrives with raster_done is still written above.
                    if (raster_done) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer on an 8x4 framebuffer. Expected writes are
// pushed to a scoreboard queue as stimulus is driven, and a monitor pops and
// compares them whenever the DUT asserts fb_we.
module tb_pixel_writer;

    localparam int CW = 32;
    localparam int HR = 8;
    localparam int VR = 4;
    localparam int KW = 8;
    localparam int AW = 5;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start;
    logic          clear_en;
    logic [KW-1:0] clear_color;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [KW-1:0] color;
    logic          drawing;
    logic          raster_done;
    logic [AW-1:0] fb_addr;
    logic [KW-1:0] fb_data;
    logic          fb_we;
    logic          ready;
    logic          busy;
    logic          frame_done;
    logic [31:0]   pixels_written;
    logic [31:0]   pixels_clipped;

    int n_total = 0;
    int n_bad   = 0;
    int exp_w   = 0;
    int exp_c   = 0;

    // Scoreboard entries are {addr, data}.
    logic [15:0] sb[$];

    pixel_writer #(
        .COORD_WIDTH(CW),
        .H_RES      (HR),
        .V_RES      (VR),
        .COLOR_WIDTH(KW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start         (start),
        .clear_en      (clear_en),
        .clear_color   (clear_color),
        .x             (x),
        .y             (y),
        .color         (color),
        .drawing       (drawing),
        .raster_done   (raster_done),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .fb_we         (fb_we),
        .ready         (ready),
        .busy          (busy),
        .frame_done    (frame_done),
        .pixels_written(pixels_written),
        .pixels_clipped(pixels_clipped)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Presents one pixel and updates the model. Only called while in ACCEPT.
    task automatic drive_pixel(input int px, input int py, input logic [KW-1:0] c);
        logic [AW-1:0] a;
        x       = px;
        y       = py;
        color   = c;
        drawing = 1'b1;
        if (px >= 0 && px < HR && py >= 0 && py < VR) begin
            a = AW'(py * HR + px);
            sb.push_back({3'b000, a, c});
            exp_w++;
        end else begin
            exp_c++;
        end
    endtask

    // Monitor: each write must match the oldest expected entry.
    always @(negedge clk_in) begin
        if (fb_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {fb_addr, fb_data}, 0);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                check("wr_addr", fb_addr, e[12:8]);
                check("wr_data", fb_data, e[7:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_cnt;
        rst_in = 1'b1;
        start = 1'b0;
        clear_en = 1'b0;
        clear_color = '0;
        x = '0;
        y = '0;
        color = '0;
        drawing = 1'b0;
        raster_done = 1'b0;
        #2;
        check("rst_we", fb_we, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_data", fb_data, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_written", pixels_written, 0);
        check("rst_clipped", pixels_clipped, 0);
        cyc();
        cyc();
        rst_in = 1'b0;
        cyc();

        // Clear phase: 32 writes of 0x3C, with drawing asserted to show it is ignored.
        start = 1'b1;
        clear_en = 1'b1;
        clear_color = 8'h3C;
        for (int i = 0; i < HR * VR; i++) sb.push_back({3'b000, AW'(i), 8'h3C});
        exp_w = 0;
        exp_c = 0;
        cyc();
        start = 1'b0;
        clear_en = 1'b0;
        x = 1;
        y = 1;
        color = 8'hEE;
        drawing = 1'b1;
        we_cnt = 0;
        for (int i = 0; i < HR * VR; i++) begin
            if (fb_we) we_cnt++;
            cyc();
        end
        drawing = 1'b0;
        check("clear_we_cycles", we_cnt, HR * VR);
        check("clear_ready", ready, 1);
        check("clear_we_off", fb_we, 0);
        check("clear_sb_empty", sb.size(), 0);
        check("clear_written", pixels_written, 0);

        // Single in-bounds pixel.
        drive_pixel(3, 2, 8'hA5);
        cyc();
        drawing = 1'b0;
        check("px_we", fb_we, 1);
        check("px_addr", fb_addr, 19);
        check("px_data", fb_data, 8'hA5);
        check("px_written", pixels_written, exp_w);
        cyc();
        check("px_we_off", fb_we, 0);
        check("px_addr_hold", fb_addr, 19);

        // Back-to-back clipping case.
        drive_pixel(-1, 0, 8'h01);
        cyc();
        drive_pixel(8, 1, 8'h02);
        cyc();
        drive_pixel(0, 4, 8'h03);
        cyc();
        drive_pixel(7, 3, 8'h04);
        cyc();
        drawing = 1'b0;
        cyc();
        check("clip_clipped", pixels_clipped, exp_c);
        check("clip_written", pixels_written, exp_w);
        check("clip_sb_empty", sb.size(), 0);

        // Corners, then a sustained random burst with gaps.
        drive_pixel(0, 0, 8'h10);
        cyc();
        drive_pixel(7, 0, 8'h11);
        cyc();
        drive_pixel(0, 3, 8'h12);
        cyc();
        drive_pixel(-100000, 2, 8'h13);
        cyc();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                drive_pixel($urandom_range(0, 13) - 3, $urandom_range(0, 8) - 2,
                            KW'($urandom_range(0, 255)));
            end else begin
                drawing = 1'b0;
            end
            cyc();
        end
        drawing = 1'b0;
        cyc();
        check("burst_written", pixels_written, exp_w);
        check("burst_clipped", pixels_clipped, exp_c);

        // Final pixel coincident with raster_done drains during FLUSH.
        drive_pixel(1, 1, 8'h5A);
        raster_done = 1'b1;
        cyc();
        drawing = 1'b0;
        raster_done = 1'b0;
        check("flush_done", frame_done, 1);
        check("flush_we", fb_we, 1);
        check("flush_addr", fb_addr, 9);
        check("flush_busy", busy, 1);
        check("flush_ready", ready, 0);
        cyc();
        check("idle_done", frame_done, 0);
        check("idle_busy", busy, 0);
        check("idle_we", fb_we, 0);
        check("idle_written", pixels_written, exp_w);
        check("idle_clipped", pixels_clipped, exp_c);

        // Drawing in IDLE is ignored.
        x = 2;
        y = 2;
        color = 8'h77;
        drawing = 1'b1;
        cyc();
        cyc();
        cyc();
        drawing = 1'b0;
        check("idle_draw_busy", busy, 0);
        check("idle_draw_written", pixels_written, exp_w);
        check("idle_draw_clipped", pixels_clipped, exp_c);

        // Start without clear; a second start while busy is ignored.
        start = 1'b1;
        clear_en = 1'b0;
        exp_w = 0;
        exp_c = 0;
        cyc();
        check("noclr_ready", ready, 1);
        check("noclr_written", pixels_written, 0);
        check("noclr_clipped", pixels_clipped, 0);
        clear_en = 1'b1;
        clear_color = 8'h99;
        cyc();
        start = 1'b0;
        clear_en = 1'b0;
        check("busy_start_ready", ready, 1);
        check("busy_start_we", fb_we, 0);
        drive_pixel(9, 0, 8'h20);
        cyc();
        drive_pixel(4, 1, 8'h21);
        raster_done = 1'b1;
        cyc();
        drawing = 1'b0;
        raster_done = 1'b0;
        check("f2_done", frame_done, 1);
        check("f2_written", pixels_written, exp_w);
        check("f2_clipped", pixels_clipped, exp_c);
        cyc();
        check("f2_busy", busy, 0);

        // Reset while the clear is at address 10.
        start = 1'b1;
        clear_en = 1'b1;
        clear_color = 8'hC3;
        for (int i = 0; i < 10; i++) sb.push_back({3'b000, AW'(i), 8'hC3});
        cyc();
        start = 1'b0;
        clear_en = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        check("pre_rst_addr", fb_addr, 10);
        rst_in = 1'b1;
        #1;
        check("arst_we", fb_we, 0);
        check("arst_busy", busy, 0);
        check("arst_addr", fb_addr, 0);
        check("arst_data", fb_data, 0);
        cyc();
        cyc();
        rst_in = 1'b0;
        cyc();
        cyc();
        check("post_rst_sb_empty", sb.size(), 0);
        start = 1'b1;
        clear_en = 1'b0;
        exp_w = 0;
        exp_c = 0;
        cyc();
        start = 1'b0;
        check("fresh_ready", ready, 1);
        check("fresh_written", pixels_written, 0);
        check("fresh_clipped", pixels_clipped, 0);
        drive_pixel(6, 2, 8'h42);
        cyc();
        drawing = 1'b0;
        check("fresh_px_written", pixels_written, exp_w);
        raster_done = 1'b1;
        cyc();
        raster_done = 1'b0;
        cyc();
        check("end_busy", busy, 0);
        check("end_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
